// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types and constants for the servo PWM bank
// Contents:
//   fetch_state_t  fetch FSM state encoding
//   EN_BIT         command-word enable bit position
//   bits_for       counter width for a modulus (at least 1 bit)
//   prod_bits      width of pos*(MAX_US-MIN_US) before the >>POS_W scaling
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_t;

  localparam int EN_BIT = 31;

  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int prod_bits(input int pos_w, input int span);
    return pos_w + $clog2(span + 1);
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// rtl/servo_pwm_channel.sv - one servo channel: active command register and pulse compare
// Ports:
//   clock, resetn  clock, asynchronous active-low reset
//   load           copy cmd_en/cmd_pos into the active registers (frame boundary)
//   out_en         output permitted this cycle (run held across two edges)
//   cmd_en         shadowed enable bit
//   cmd_pos        shadowed position
//   us_cnt         frame microsecond counter
//   pwm            registered pulse output
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int MIN_US = 1000,
  parameter int MAX_US = 2000,
  parameter int POS_W  = 8,
  parameter int CNT_W  = 15
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             out_en,
  input  logic             cmd_en,
  input  logic [POS_W-1:0] cmd_pos,
  input  logic [CNT_W-1:0] us_cnt,
  output logic             pwm
);

  localparam int SPAN   = MAX_US - MIN_US;
  localparam int PROD_W = prod_bits(POS_W, SPAN);
  localparam int WID_W  = $clog2(MAX_US + 1);

  logic [PROD_W-1:0] prod;
  logic [WID_W-1:0]  width_calc;
  logic [WID_W-1:0]  active_width;
  logic              active_en;

  // Truncating scale: the top position stays strictly below MAX_US.
  assign prod       = PROD_W'(cmd_pos) * PROD_W'(SPAN);
  assign width_calc = WID_W'(MIN_US) + WID_W'(prod >> POS_W);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      active_en    <= 1'b0;
      active_width <= '0;
      pwm          <= 1'b0;
    end else begin
      if (load) begin
        active_en    <= cmd_en;
        active_width <= width_calc;
      end
      // Compare uses the pre-load width, so the boundary cycle still ends the old frame.
      pwm <= out_en & active_en & (32'(us_cnt) < 32'(active_width));
    end
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// rtl/servo_pwm_bank.sv - N-channel servo PWM generator with per-frame dmem command fetch
// Ports:
//   clock, resetn  clock, asynchronous active-low reset
//   run            global enable; low holds counters at 0 and forces outputs low
//   dmem_req       read request, held until granted
//   dmem_addr      read address (BASE_ADDR + channel), 0 when not requesting
//   dmem_gnt       grant; request accepted on an edge with req & gnt
//   dmem_rdata     read data, valid the cycle after acceptance
//   servo_pwm      registered per-channel pulse outputs
//   frame_start    1-cycle pulse after each frame boundary
//   overrun        1-cycle pulse when a boundary finds the fetch unfinished
//   busy           fetch sequence in progress
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int                NUM_CH    = 8,
  parameter int                CLK_HZ    = 50_000_000,
  parameter int                PERIOD_US = 20000,
  parameter int                MIN_US    = 1000,
  parameter int                MAX_US    = 2000,
  parameter int                POS_W     = 8,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_gnt,
  input  logic [31:0]       dmem_rdata,
  output logic [NUM_CH-1:0] servo_pwm,
  output logic              frame_start,
  output logic              overrun,
  output logic              busy
);

  localparam int TICKS = CLK_HZ / 1_000_000;
  localparam int PS_W  = bits_for(TICKS);
  localparam int CNT_W = bits_for(PERIOD_US);
  localparam int CH_W  = bits_for(NUM_CH);

  logic [PS_W-1:0]  prescaler;
  logic [CNT_W-1:0] us_cnt;
  logic             run_d;
  logic             boundary;
  logic             load;
  logic             fetch_start;
  logic             out_en;

  fetch_state_t     state, state_n;
  logic [CH_W-1:0]  ch, ch_n;
  logic             capture;
  logic             set_valid;
  logic             shadow_valid;

  logic [NUM_CH-1:0]            shadow_en;
  logic [NUM_CH-1:0][POS_W-1:0] shadow_pos;

  // Command bits between the position field and the enable bit carry nothing.
  logic unused_rdata;
  assign unused_rdata = ^dmem_rdata[EN_BIT-1:POS_W];

  // A rising run acts as a boundary so a resumed bank starts on a clean frame.
  assign boundary = run & (~run_d |
                    ((prescaler == PS_W'(TICKS - 1)) && (us_cnt == CNT_W'(PERIOD_US - 1))));
  assign load        = boundary & shadow_valid;
  // With no shadow set ready and nothing in flight (after reset or an aborted
  // fetch) the boundary kicks off a fetch; the set it gathers loads next frame.
  assign fetch_start = boundary & (shadow_valid | (state == ST_IDLE));
  // Gate the run-rising edge too, so a resumed frame's pulse is exactly width*TICKS.
  assign out_en      = run & run_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prescaler   <= '0;
      us_cnt      <= '0;
      run_d       <= 1'b0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      run_d       <= run;
      frame_start <= boundary;
      overrun     <= boundary & ~shadow_valid & (state != ST_IDLE);
      if (!run || boundary) begin
        prescaler <= '0;
        us_cnt    <= '0;
      end else if (prescaler == PS_W'(TICKS - 1)) begin
        prescaler <= '0;
        us_cnt    <= us_cnt + CNT_W'(1);
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      ch    <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
    end
  end

  always_comb begin
    state_n   = state;
    ch_n      = ch;
    capture   = 1'b0;
    set_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fetch_start) begin
          state_n = ST_REQ;
          ch_n    = '0;
        end
      end
      ST_REQ: begin
        // The handshake always completes; a stopped bank just drops the sequence after it.
        if (dmem_gnt) state_n = run ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        capture = 1'b1;
        if (!run) begin
          state_n = ST_IDLE;
        end else if (ch == CH_W'(NUM_CH - 1)) begin
          state_n = ST_DONE;
        end else begin
          ch_n    = ch + CH_W'(1);
          state_n = ST_REQ;
        end
      end
      ST_DONE: begin
        set_valid = 1'b1;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shadow_en    <= '0;
      shadow_pos   <= '0;
      shadow_valid <= 1'b0;
    end else begin
      if (capture) begin
        shadow_en[ch]  <= dmem_rdata[EN_BIT];
        shadow_pos[ch] <= dmem_rdata[POS_W-1:0];
      end
      if (load) begin
        shadow_valid <= 1'b0;
      end else if (set_valid) begin
        shadow_valid <= 1'b1;
      end
    end
  end

  assign dmem_req  = (state == ST_REQ);
  assign dmem_addr = (state == ST_REQ) ? BASE_ADDR + ADDR_W'(ch) : '0;
  assign busy      = (state != ST_IDLE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_channel #(
      .MIN_US (MIN_US),
      .MAX_US (MAX_US),
      .POS_W  (POS_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clock   (clock),
      .resetn  (resetn),
      .load    (load),
      .out_en  (out_en),
      .cmd_en  (shadow_en[i]),
      .cmd_pos (shadow_pos[i]),
      .us_cnt  (us_cnt),
      .pwm     (servo_pwm[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb/tb_servo_pwm_bank.sv - directed self-checking bench for servo_pwm_bank
module tb_servo_pwm_bank;

  logic        clock = 1'b0;
  logic        resetn;
  logic        run;
  logic        dmem_req;
  logic [11:0] dmem_addr;
  logic        dmem_gnt;
  logic [31:0] dmem_rdata = '0;
  logic [1:0]  servo_pwm;
  logic        frame_start;
  logic        overrun;
  logic        busy;

  logic [31:0] mem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  servo_pwm_bank #(
    .NUM_CH    (2),
    .CLK_HZ    (4_000_000),
    .PERIOD_US (100),
    .MIN_US    (10),
    .MAX_US    (20),
    .POS_W     (4),
    .ADDR_W    (12),
    .BASE_ADDR (12'h010)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .run         (run),
    .dmem_req    (dmem_req),
    .dmem_addr   (dmem_addr),
    .dmem_gnt    (dmem_gnt),
    .dmem_rdata  (dmem_rdata),
    .servo_pwm   (servo_pwm),
    .frame_start (frame_start),
    .overrun     (overrun),
    .busy        (busy)
  );

  always @(posedge clock) begin
    if (dmem_req && dmem_gnt) dmem_rdata <= mem[dmem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    while (!frame_start && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_fs_seen"}, 32'(frame_start), 32'd1);
  endtask

  // Called on the negedge where frame_start is high; ends on the next one.
  task automatic frame(input string tag, input int exp0, input int exp1, input int exp_ov,
                       input int poke_k, input logic [31:0] poke_d, input int gnt_k);
    int hi0 = 0;
    int hi1 = 0;
    int fs  = 0;
    int ov  = 0;
    for (int k = 0; k < 400; k++) begin
      if (k == poke_k) mem[12'h011] = poke_d;
      if (k == gnt_k) dmem_gnt = 1'b1;
      if (servo_pwm[0]) hi0++;
      if (servo_pwm[1]) hi1++;
      if (frame_start) fs++;
      if (overrun) ov++;
      @(negedge clock);
    end
    check({tag, "_ch0_width"}, 32'(hi0), 32'(exp0));
    check({tag, "_ch1_width"}, 32'(hi1), 32'(exp1));
    check({tag, "_overrun"}, 32'(ov), 32'(exp_ov));
    check({tag, "_fs_count"}, 32'(fs), 32'd1);
    check({tag, "_fs_period"}, 32'(frame_start), 32'd1);
  endtask

  initial begin
    resetn   = 1'b0;
    run      = 1'b0;
    dmem_gnt = 1'b1;
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    mem[12'h010] = 32'h8000_0000;
    mem[12'h011] = 32'h8000_000F;

    repeat (3) @(negedge clock);
    check("rst_pwm", 32'(servo_pwm), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_addr", 32'(dmem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);

    resetn = 1'b1;
    @(negedge clock);
    check("norun_req", 32'(dmem_req), 32'd0);

    // Scenario 1
    run = 1'b1;
    wait_fs("s1");
    check("s1_busy", 32'(busy), 32'd1);
    frame("s1_f1", 0, 0, 0, -1, 32'h0, -1);
    frame("s1_f2", 40, 76, 0, -1, 32'h0, -1);

    // Scenario 2: new commands fetched at this boundary, visible one frame later
    mem[12'h010] = 32'h8000_0008;
    mem[12'h011] = 32'h0000_000F;
    frame("s2_f3", 40, 76, 0, -1, 32'h0, -1);

    // Scenario 4: mid-frame change after the fetch
    frame("s2_f4", 60, 0, 0, 200, 32'h8000_0004, -1);
    frame("s4_f5", 60, 0, 0, -1, 32'h0, -1);
    frame("s4_f6", 60, 48, 0, -1, 32'h0, -1);

    // Scenario 3: grant withheld for 500 cycles
    dmem_gnt = 1'b0;
    mem[12'h010] = 32'h8000_000F;
    frame("s3_f7", 60, 48, 0, -1, 32'h0, -1);
    check("s3_req_held", 32'(dmem_req), 32'd1);
    check("s3_addr_held", 32'(dmem_addr), 32'h010);
    check("s3_busy", 32'(busy), 32'd1);
    frame("s3_f8", 60, 48, 1, -1, 32'h0, 100);
    frame("s3_f9", 76, 48, 0, -1, 32'h0, -1);

    // Scenario 5: async reset mid-REQ and mid-pulse
    dmem_gnt = 1'b0;
    repeat (20) @(negedge clock);
    check("s5_pre_pwm", 32'(servo_pwm), 32'd3);
    check("s5_pre_req", 32'(dmem_req), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("s5_req", 32'(dmem_req), 32'd0);
    check("s5_pwm", 32'(servo_pwm), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_fs", 32'(frame_start), 32'd0);
    mem[12'h010] = 32'h8000_0000;
    mem[12'h011] = 32'h8000_000F;
    dmem_gnt = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    wait_fs("s5");
    frame("s5_f1", 0, 0, 0, -1, 32'h0, -1);
    frame("s5_f2", 40, 76, 0, -1, 32'h0, -1);

    // Scenario 6: run low for 50 cycles mid-frame
    repeat (30) @(negedge clock);
    check("s6_pre_pwm", 32'(servo_pwm), 32'd3);
    run = 1'b0;
    @(negedge clock);
    check("s6_pwm_off", 32'(servo_pwm), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);
    repeat (49) @(negedge clock);
    check("s6_pwm_held", 32'(servo_pwm), 32'd0);
    check("s6_req", 32'(dmem_req), 32'd0);
    check("s6_fs_low", 32'(frame_start), 32'd0);
    run = 1'b1;
    @(negedge clock);
    check("s6_fs_resume", 32'(frame_start), 32'd1);
    frame("s6_f", 40, 76, 0, -1, 32'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
